// File: rtl/nf_mem_arbiter_if.sv
// Request/ack ports of the IFU and LSU plus the single-port memory bus of nf_mem_arbiter.
// The arbiter takes the slave view; the CPU stages and memory model together take the master view.
interface nf_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  mem_rdata,
        output if_rdata, if_ack,
        output lsu_rdata, lsu_ack,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output mem_rdata,
        input  if_rdata, if_ack,
        input  lsu_rdata, lsu_ack,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/nf_mem_arbiter.sv
// Shares one single-port memory between the nanoFOX fetch unit and load/store unit.
// Each access runs IDLE -> CMD -> (WAIT) -> RESP; the LSU wins ties unless the fetch side is starved.
module nf_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             resetn,
    nf_mem_arbiter_if.slave  bus
);
    localparam int LAT_W    = 3;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t              state_q,      state_d;
    owner_t              owner_q,      owner_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q,    lat_cnt_d;
    logic                write_q,      write_d;
    logic                mem_re_q,     mem_re_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;

    logic starved;
    logic grant_lsu;
    logic grant_if;

    // A pending fetch overrides the LSU only once STARVE_MAX LSU grants have passed it by.
    assign starved   = (starve_cnt_q == STARVE_W'(STARVE_MAX));
    assign grant_lsu = bus.lsu_req && !(bus.if_req && starved);
    assign grant_if  = bus.if_req && !grant_lsu;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        write_d      = write_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    owner_d    = OWN_LSU;
                    write_d    = bus.lsu_we;
                    mem_addr_d = bus.lsu_addr;
                    mem_we_d   = bus.lsu_we;
                    mem_re_d   = !bus.lsu_we;
                    if (bus.lsu_we) begin
                        mem_wdata_d = bus.lsu_wdata;
                    end
                    if (bus.if_req && !starved) begin
                        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                    end
                    state_d = ST_CMD;
                end else if (grant_if) begin
                    owner_d      = OWN_IFU;
                    write_d      = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    mem_re_d     = 1'b1;
                    starve_cnt_d = '0;
                    state_d      = ST_CMD;
                end
            end
            ST_CMD: begin
                if (write_q || (MEM_LAT == 1)) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = LAT_W'(MEM_LAT - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            starve_cnt_q <= '0;
            lat_cnt_q    <= '0;
            write_q      <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            write_q      <= write_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Acks decode straight from state so an asynchronous reset kills them immediately.
    assign bus.if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign bus.lsu_ack   = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.lsu_rdata = bus.mem_rdata;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_nf_mem_arbiter.sv
// Bench for nf_mem_arbiter: three instances with memory latencies 1, 3 and 4, each checked every
// cycle against a transaction-level model of grant order, command timing and ack timing.
module tb_nf_mem_arbiter;
    localparam int NL         = 3;
    localparam int STARVE_MAX = 4;

    function automatic int lat_of(int l);
        case (l)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] memf(logic [31:0] a);
        if (a == 32'h10) return 32'h93;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic clk;
    logic resetn;

    logic [NL-1:0]        t_if_req, t_lsu_req, t_lsu_we;
    logic [NL-1:0][31:0]  t_if_addr, t_lsu_addr, t_lsu_wdata, t_mem_rdata;
    logic [NL-1:0]        o_if_ack, o_lsu_ack, o_mem_re, o_mem_we, o_busy;
    logic [NL-1:0][31:0]  o_if_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            nf_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();
            assign bus_if.if_req    = t_if_req[gi];
            assign bus_if.if_addr   = t_if_addr[gi];
            assign bus_if.lsu_req   = t_lsu_req[gi];
            assign bus_if.lsu_we    = t_lsu_we[gi];
            assign bus_if.lsu_addr  = t_lsu_addr[gi];
            assign bus_if.lsu_wdata = t_lsu_wdata[gi];
            assign bus_if.mem_rdata = t_mem_rdata[gi];
            assign o_if_ack[gi]     = bus_if.if_ack;
            assign o_lsu_ack[gi]    = bus_if.lsu_ack;
            assign o_mem_re[gi]     = bus_if.mem_re;
            assign o_mem_we[gi]     = bus_if.mem_we;
            assign o_busy[gi]       = bus_if.busy;
            assign o_if_rdata[gi]   = bus_if.if_rdata;
            assign o_lsu_rdata[gi]  = bus_if.lsu_rdata;
            assign o_mem_addr[gi]   = bus_if.mem_addr;
            assign o_mem_wdata[gi]  = bus_if.mem_wdata;

            nf_mem_arbiter #(
                .ADDR_W    (32),
                .DATA_W    (32),
                .MEM_LAT   (lat_of(gi)),
                .STARVE_MAX(STARVE_MAX)
            ) u_dut (
                .clk   (clk),
                .resetn(resetn),
                .bus   (bus_if.slave)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = 0;           // 0 directed, 1 both held, 2 random
    bit release_now = 0;
    bit rec      = 0;

    // requesters
    bit [NL-1:0]         ifp, lp, lwe;
    logic [NL-1:0][31:0] ia, la, lwd;
    // memory model
    int                  rd_due [NL];
    logic [31:0]         rd_addr [NL];
    // reference model: one access record per lane
    bit                  tr_valid [NL];
    bit                  tr_lsu [NL];
    bit                  tr_we [NL];
    logic [31:0]         tr_addr [NL];
    int                  tr_grant [NL];
    int                  tr_ack [NL];
    int                  next_idle [NL];
    int                  starve [NL];
    logic [31:0]         last_addr [NL];
    logic [31:0]         last_wdata [NL];
    // observations
    int                  if_ack_cyc [NL];
    int                  lsu_ack_cyc [NL];
    logic [9:0]          seq_bits [NL];
    int                  seq_n [NL];

    task automatic chk(string tag, int lane, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s lane=%0d cyc=%0d observed=%h expected=%h", tag, lane, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(int l);
        tr_valid[l]   = 0;
        next_idle[l]  = 32'h3FFF_FFFF;
        starve[l]     = 0;
        last_addr[l]  = '0;
        last_wdata[l] = '0;
        rd_due[l]     = -1;
        ifp[l]        = 0;
        lp[l]         = 0;
    endtask

    task automatic check_lane(int l);
        bit act, e_busy, e_re, e_we, e_ifa, e_lsa;
        act    = tr_valid[l];
        e_busy = act && (cyc > tr_grant[l]) && (cyc <= tr_ack[l]);
        e_re   = act && (cyc == tr_grant[l] + 1) && !tr_we[l];
        e_we   = act && (cyc == tr_grant[l] + 1) && tr_we[l];
        e_ifa  = act && (cyc == tr_ack[l]) && !tr_lsu[l];
        e_lsa  = act && (cyc == tr_ack[l]) && tr_lsu[l];
        chk("busy",      l, 32'(o_busy[l]),   32'(e_busy));
        chk("mem_re",    l, 32'(o_mem_re[l]), 32'(e_re));
        chk("mem_we",    l, 32'(o_mem_we[l]), 32'(e_we));
        chk("if_ack",    l, 32'(o_if_ack[l]), 32'(e_ifa));
        chk("lsu_ack",   l, 32'(o_lsu_ack[l]), 32'(e_lsa));
        chk("mem_addr",  l, o_mem_addr[l],  last_addr[l]);
        chk("mem_wdata", l, o_mem_wdata[l], last_wdata[l]);
        if (e_ifa) chk("if_rdata", l, o_if_rdata[l], memf(tr_addr[l]));
        if (e_lsa && !tr_we[l]) chk("lsu_rdata", l, o_lsu_rdata[l], memf(tr_addr[l]));
    endtask

    task automatic decide(int l);
        bit rq_if, rq_ls, win_lsu;
        rq_if = t_if_req[l];
        rq_ls = t_lsu_req[l];
        if (!resetn || cyc < next_idle[l] || !(rq_if || rq_ls)) return;
        if (rq_if && rq_ls) win_lsu = (starve[l] != STARVE_MAX);
        else                win_lsu = rq_ls;
        if (win_lsu) begin
            if (rq_if && starve[l] < STARVE_MAX) starve[l]++;
        end else begin
            starve[l] = 0;
        end
        tr_valid[l] = 1;
        tr_lsu[l]   = win_lsu;
        tr_we[l]    = win_lsu && t_lsu_we[l];
        tr_addr[l]  = win_lsu ? t_lsu_addr[l] : t_if_addr[l];
        tr_grant[l] = cyc;
        tr_ack[l]   = tr_we[l] ? cyc + 2 : cyc + 1 + lat_of(l);
        next_idle[l] = tr_ack[l] + 1;
        last_addr[l] = tr_addr[l];
        if (tr_we[l]) last_wdata[l] = t_lsu_wdata[l];
    endtask

    task automatic observe(int l);
        if (o_if_ack[l]) begin
            ifp[l] = 0;
            if_ack_cyc[l] = cyc;
            if (rec && seq_n[l] < 10) begin seq_bits[l] = {seq_bits[l][8:0], 1'b0}; seq_n[l]++; end
        end
        if (o_lsu_ack[l]) begin
            lp[l] = 0;
            lsu_ack_cyc[l] = cyc;
            if (rec && seq_n[l] < 10) begin seq_bits[l] = {seq_bits[l][8:0], 1'b1}; seq_n[l]++; end
        end
        if (o_mem_re[l]) begin
            rd_due[l]  = cyc + lat_of(l);
            rd_addr[l] = o_mem_addr[l];
        end
    endtask

    function automatic bit roll();
        if (mode == 1) return 1;
        if (mode == 2) return ($urandom_range(0, 2) == 0);
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (release_now) begin
            resetn = 1'b1;
            release_now = 0;
            for (int l = 0; l < NL; l++) next_idle[l] = cyc;
        end
        for (int l = 0; l < NL; l++) begin
            if (resetn) begin
                if (!ifp[l] && roll()) begin ifp[l] = 1; ia[l] = $urandom & 32'hFFFF_FFFC; end
                if (!lp[l] && roll()) begin
                    lp[l] = 1; la[l] = $urandom & 32'hFFFF_FFFC; lwe[l] = 1'($urandom_range(0, 1)); lwd[l] = $urandom;
                end
            end
            t_if_req[l]    = ifp[l];
            t_if_addr[l]   = ia[l];
            t_lsu_req[l]   = lp[l];
            t_lsu_we[l]    = lwe[l];
            t_lsu_addr[l]  = la[l];
            t_lsu_wdata[l] = lwd[l];
            t_mem_rdata[l] = (cyc == rd_due[l]) ? memf(rd_addr[l]) : (32'hBAD0_0000 ^ 32'(cyc));
        end
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            check_lane(l);
            decide(l);
            observe(l);
        end
    endtask

    task automatic issue_if(logic [31:0] a);
        for (int l = 0; l < NL; l++) begin ifp[l] = 1; ia[l] = a; end
    endtask

    task automatic issue_lsu(bit we, logic [31:0] a, logic [31:0] d);
        for (int l = 0; l < NL; l++) begin lp[l] = 1; lwe[l] = we; la[l] = a; lwd[l] = d; end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        for (int l = 0; l < NL; l++) begin
            model_reset(l);
            ia[l] = '0; la[l] = '0; lwd[l] = '0; lwe[l] = 0;
            if_ack_cyc[l] = -1; lsu_ack_cyc[l] = -1;
            seq_bits[l] = '0; seq_n[l] = 0;
        end
        t_if_req = '0; t_lsu_req = '0; t_lsu_we = '0;
        t_if_addr = '0; t_lsu_addr = '0; t_lsu_wdata = '0; t_mem_rdata = '0;

        // reset values, then release
        repeat (3) step();
        release_now = 1;
        step();

        // single fetch from 0x10: memory returns 0x93
        issue_if(32'h10);
        n = cyc + 1;
        repeat (8) step();
        for (int l = 0; l < NL; l++) chk("fetch_ack_cycle", l, 32'(if_ack_cyc[l]), 32'(n + 1 + lat_of(l)));

        // store 0xDEADBEEF to 0x100
        issue_lsu(1'b1, 32'h100, 32'hDEAD_BEEF);
        n = cyc + 1;
        repeat (6) step();
        for (int l = 0; l < NL; l++) chk("store_ack_cycle", l, 32'(lsu_ack_cyc[l]), 32'(n + 2));

        // load from 0x200
        issue_lsu(1'b0, 32'h200, 32'h0);
        n = cyc + 1;
        repeat (8) step();
        for (int l = 0; l < NL; l++) chk("load_ack_cycle", l, 32'(lsu_ack_cyc[l]), 32'(n + 1 + lat_of(l)));

        // fetch, then reset mid-cycle while the latency-3/4 lanes wait on memory
        issue_if(32'h40);
        repeat (4) step();
        #2;
        resetn = 1'b0;
        #1;
        for (int l = 0; l < NL; l++) begin
            chk("rst_busy",    l, 32'(o_busy[l]),    32'h0);
            chk("rst_mem_re",  l, 32'(o_mem_re[l]),  32'h0);
            chk("rst_mem_we",  l, 32'(o_mem_we[l]),  32'h0);
            chk("rst_if_ack",  l, 32'(o_if_ack[l]),  32'h0);
            chk("rst_lsu_ack", l, 32'(o_lsu_ack[l]), 32'h0);
            chk("rst_addr",    l, o_mem_addr[l],     32'h0);
            chk("rst_wdata",   l, o_mem_wdata[l],    32'h0);
            model_reset(l);
        end
        repeat (2) step();

        // both requesters held from reset release: LSU x4, IFU, LSU x4, IFU
        mode = 1;
        rec  = 1;
        release_now = 1;
        repeat (80) step();
        rec = 0;
        for (int l = 0; l < NL; l++) begin
            chk("grant_count", l, 32'(seq_n[l] >= 10), 32'h1);
            chk("grant_order", l, 32'(seq_bits[l]), 32'(10'b11110_11110));
        end

        // random traffic, then drain whatever is still pending
        mode = 2;
        repeat (800) step();
        mode = 0;
        repeat (12) step();
        for (int l = 0; l < NL; l++) chk("drained", l, 32'({ifp[l], lp[l]}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
